// File: rtl/pdm_pkg.sv
// Shared types and PDM-to-PCM arithmetic for the PDM microphone front end.
package pdm_pkg;

  typedef enum logic {StIdle, StRun} pdm_state_e;

  function automatic int unsigned tally_width(int unsigned decim);
    return $clog2(decim + 1);
  endfunction

  function automatic int unsigned pcm_shift(int unsigned decim, int unsigned out_width);
    return out_width - 1 - $clog2(decim);
  endfunction

  // Centre the ones count around zero, scale to full range, clip the single
  // positive overflow code (all ones) to the largest positive sample.
  function automatic int pdm_to_pcm(int unsigned count, int unsigned decim,
                                    int unsigned out_width);
    int v;
    int max_val;
    v       = (2 * int'(count) - int'(decim)) <<< pcm_shift(decim, out_width);
    max_val = (1 <<< (out_width - 1)) - 1;
    return (v > max_val) ? max_val : v;
  endfunction

endpackage

// File: rtl/pdm_mic_frontend_if.sv
// Decimated PCM output bundle of the PDM front end.
interface pdm_mic_frontend_if #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                        pdm_tick_out;
  logic                        sample_valid_out;
  logic signed [OUT_WIDTH-1:0] sample_out [CHANNELS];

  modport master (output pdm_tick_out, output sample_valid_out, output sample_out);
  modport slave  (input pdm_tick_out, input sample_valid_out, input sample_out);
endinterface

// File: rtl/pdm_boxcar_channel.sv
// One PDM channel: counts ones over a window and converts the tally to a
// registered, centred, saturated PCM sample at window end.
module pdm_boxcar_channel
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM     = 256,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        sample_en_i,
  input  logic                        bit_i,
  input  logic                        win_end_i,
  output logic signed [OUT_WIDTH-1:0] pcm_o
);

  localparam int unsigned TallyW = tally_width(DECIM);

  logic [TallyW-1:0]           tally_q, tally_d, tally_inc;
  logic signed [OUT_WIDTH-1:0] pcm_q, pcm_d;

  always_comb begin
    // The window-end bit may arrive in the same cycle as the window end.
    tally_inc = tally_q + TallyW'(sample_en_i & bit_i);
    tally_d   = tally_inc;
    pcm_d     = pcm_q;
    if (clear_i) begin
      tally_d = '0;
    end else if (win_end_i) begin
      tally_d = '0;
      pcm_d   = OUT_WIDTH'(pdm_to_pcm(32'(tally_inc), DECIM, OUT_WIDTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tally_q <= '0;
      pcm_q   <= '0;
    end else begin
      tally_q <= tally_d;
      pcm_q   <= pcm_d;
    end
  end

  assign pcm_o = pcm_q;

endmodule

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: mic clock divider, interleaved channel capture and
// per-channel boxcar decimation to PCM.
module pdm_mic_frontend
  import pdm_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CLK_DIV   = 32,
  parameter int unsigned DECIM     = 256,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  output logic                mic_clk_out,
  input  logic                mic_data_in,
  pdm_mic_frontend_if.master  pcm_if
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned WinW = $clog2(DECIM);

  pdm_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WinW-1:0] win_q, win_d;
  logic            mic_clk_q, mic_clk_d;
  logic            tick_q, tick_d;
  logic            valid_q, valid_d;

  logic            run, cnt_end, strobe0, tick, win_end;

  always_comb begin
    state_d = enable_in ? StRun : StIdle;
    // A cycle with enable low never counts, even if the FSM is still in run.
    run     = (state_q == StRun) && enable_in;
    cnt_end = (cnt_q == CntW'(CLK_DIV - 1));
    strobe0 = run && (cnt_q == CntW'(CLK_DIV / 2 - 1));
    tick    = run && cnt_end;
    win_end = tick && (win_q == WinW'(DECIM - 1));

    cnt_d = '0;
    win_d = '0;
    if (run) begin
      cnt_d = cnt_end ? '0 : cnt_q + CntW'(1);
      win_d = win_q;
      if (tick) win_d = win_end ? '0 : win_q + WinW'(1);
    end

    // Registered outputs track the next count so they stay aligned with cnt_q.
    mic_clk_d = enable_in && (cnt_d < CntW'(CLK_DIV / 2));
    tick_d    = enable_in && (cnt_d == CntW'(CLK_DIV - 1));
    valid_d   = win_end;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      win_q     <= '0;
      mic_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      mic_clk_q <= mic_clk_d;
      tick_q    <= tick_d;
      valid_q   <= valid_d;
    end
  end

  logic signed [OUT_WIDTH-1:0] pcm [CHANNELS];

  for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
    // Channel 0 samples on the last high phase, channel 1 on the last low phase.
    pdm_boxcar_channel #(
      .DECIM    (DECIM),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_channel (
      .clk_i      (clk_in),
      .rst_ni     (rst_in),
      .clear_i    (!run),
      .sample_en_i((gi == 0) ? strobe0 : tick),
      .bit_i      (mic_data_in),
      .win_end_i  (win_end),
      .pcm_o      (pcm[gi])
    );
    assign pcm_if.sample_out[gi] = pcm[gi];
  end

  assign mic_clk_out             = mic_clk_q;
  assign pcm_if.pdm_tick_out     = tick_q;
  assign pcm_if.sample_valid_out = valid_q;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Randomised and directed bench for pdm_mic_frontend against a cycle-index
// reference model, plus a small second configuration pinned by literals.
module tb_pdm_mic_frontend;

  localparam int ACD = 32;
  localparam int ADC = 256;
  localparam int AOW = 16;

  localparam int MConst  = 0;
  localparam int MMirror = 1;
  localparam int M192    = 2;
  localparam int M128    = 3;
  localparam int MRand   = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic en_a   = 1'b0;
  logic data_a = 1'b0;
  logic en_b   = 1'b0;
  logic data_b = 1'b0;
  logic mic_clk_a, mic_clk_b;

  int cyc     = 0;
  int n_chk   = 0;
  int n_err   = 0;
  int t0      = 0;
  int t0b     = 0;
  int mode    = 0;
  int mode_b  = 0;
  logic const_a = 1'b0;
  bit chk_on  = 1'b0;

  pdm_mic_frontend_if #(.CHANNELS(2), .OUT_WIDTH(16)) pcm_a ();
  pdm_mic_frontend_if #(.CHANNELS(1), .OUT_WIDTH(8))  pcm_b ();

  pdm_mic_frontend #(
    .CHANNELS(2), .CLK_DIV(32), .DECIM(256), .OUT_WIDTH(16)
  ) dut_a (
    .clk_in     (clk_in),
    .rst_in     (rst_n),
    .enable_in  (en_a),
    .mic_clk_out(mic_clk_a),
    .mic_data_in(data_a),
    .pcm_if     (pcm_a)
  );

  pdm_mic_frontend #(
    .CHANNELS(1), .CLK_DIV(8), .DECIM(16), .OUT_WIDTH(8)
  ) dut_b (
    .clk_in     (clk_in),
    .rst_in     (rst_n),
    .enable_in  (en_b),
    .mic_clk_out(mic_clk_b),
    .mic_data_in(data_b),
    .pcm_if     (pcm_b)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus data, changed just after each rising edge.
  always @(posedge clk_in) begin
    int k;
    int kb;
    #1;
    k  = cyc - t0;
    kb = cyc - t0b;
    case (mode)
      MConst:  data_a = const_a;
      MMirror: data_a = mic_clk_a;
      M192:    data_a = ((k / ACD) % 4) != 3;
      M128:    data_a = ((k / ACD) % 2) != 0;
      default: data_a = ($urandom % 2) != 0;
    endcase
    data_b = (mode_b == 0) ? 1'b1 : (((kb / 8) % 2) != 0);
  end

  // Reference model: time measured in cycles since the block entered run.
  int   m_n = -1;
  int   m_ones0 = 0, m_ones1 = 0, m_bits = 0;
  logic m_clk = 1'b0, m_tick = 1'b0, m_valid = 1'b0;
  logic signed [15:0] m_smp0 = '0, m_smp1 = '0;

  function automatic logic signed [15:0] model_pcm(input int c);
    int v;
    v = (2 * c - ADC) * (1 << (AOW - 1 - $clog2(ADC)));
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  always @(posedge clk_in or negedge rst_n) begin : model
    int   n_nx, o0, o1, b;
    logic vld;
    if (!rst_n) begin
      m_n <= -1; m_ones0 <= 0; m_ones1 <= 0; m_bits <= 0;
      m_clk <= 1'b0; m_tick <= 1'b0; m_valid <= 1'b0;
      m_smp0 <= '0; m_smp1 <= '0;
    end else begin
      o0 = m_ones0; o1 = m_ones1; b = m_bits; vld = 1'b0;
      if (m_n >= 0 && en_a) begin
        if (m_n % ACD == ACD / 2 - 1) o0 += int'(data_a);
        if (m_n % ACD == ACD - 1) begin
          o1 += int'(data_a);
          b++;
        end
        if (b == ADC) begin
          vld = 1'b1;
          m_smp0 <= model_pcm(o0);
          m_smp1 <= model_pcm(o1);
          o0 = 0; o1 = 0; b = 0;
        end
        n_nx = m_n + 1;
      end else begin
        o0 = 0; o1 = 0; b = 0;
        n_nx = (m_n < 0 && en_a) ? 0 : -1;
      end
      m_n     <= n_nx;
      m_ones0 <= o0;
      m_ones1 <= o1;
      m_bits  <= b;
      m_valid <= vld;
      m_clk   <= (n_nx >= 0) && ((n_nx % ACD) < ACD / 2);
      m_tick  <= (n_nx >= 0) && ((n_nx % ACD) == ACD - 1);
    end
  end

  always @(negedge clk_in) begin
    if (chk_on) begin
      check("mic_clk", int'(mic_clk_a), int'(m_clk));
      check("pdm_tick", int'(pcm_a.pdm_tick_out), int'(m_tick));
      check("sample_valid", int'(pcm_a.sample_valid_out), int'(m_valid));
      check("sample_ch0", int'(pcm_a.sample_out[0]), int'(m_smp0));
      check("sample_ch1", int'(pcm_a.sample_out[1]), int'(m_smp1));
    end
  end

  task automatic start_a(input int md, input logic cv);
    @(posedge clk_in); #1;
    en_a = 1'b0;
    @(posedge clk_in); #1;
    mode = md; const_a = cv;
    en_a = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic goto_a(input int k);
    while (cyc != t0 + k) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic wait_valid(input bit sel_b, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if ((sel_b ? pcm_b.sample_valid_out : pcm_a.sample_valid_out) == 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at, at2, nv, hi, first_tick;
    #3;
    check("reset_mic_clk", int'(mic_clk_a), 0);
    check("reset_tick", int'(pcm_a.pdm_tick_out), 0);
    check("reset_valid", int'(pcm_a.sample_valid_out), 0);
    check("reset_ch0", int'(pcm_a.sample_out[0]), 0);
    check("reset_ch1", int'(pcm_a.sample_out[1]), 0);
    check("reset_b_sample", int'(pcm_b.sample_out[0]), 0);
    @(posedge clk_in); #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // All ones: saturated positive, periodic valid.
    start_a(MConst, 1'b1);
    wait_valid(1'b0, 9000, at);
    check("ones_first_valid_cycle", at - t0, 8192);
    check("ones_ch0", int'(pcm_a.sample_out[0]), 32767);
    check("ones_ch1", int'(pcm_a.sample_out[1]), 32767);
    wait_valid(1'b0, 9000, at2);
    check("ones_valid_period", at2 - at, 8192);

    // All zeros, plus mic clock duty and first tick position.
    start_a(MConst, 1'b0);
    @(posedge clk_in);
    hi = 0; first_tick = -1;
    for (int k = 0; k < ACD; k++) begin
      @(negedge clk_in);
      if (k == 0) check("mic_clk_high_cycle0", int'(mic_clk_a), 1);
      if (mic_clk_a) hi++;
      if (pcm_a.pdm_tick_out && first_tick < 0) first_tick = k;
    end
    check("mic_clk_high_count", hi, 16);
    check("first_tick_cycle", first_tick, 31);
    wait_valid(1'b0, 9000, at);
    check("zeros_first_valid_cycle", at - t0, 8192);
    check("zeros_ch0", int'(pcm_a.sample_out[0]), -32768);
    check("zeros_ch1", int'(pcm_a.sample_out[1]), -32768);

    // Data follows the mic clock: ch0 sees ones, ch1 sees zeros.
    start_a(MMirror, 1'b0);
    wait_valid(1'b0, 9000, at);
    check("mirror_ch0", int'(pcm_a.sample_out[0]), 32767);
    check("mirror_ch1", int'(pcm_a.sample_out[1]), -32768);

    // 192 ones of 256.
    start_a(M192, 1'b0);
    wait_valid(1'b0, 9000, at);
    check("d192_ch0", int'(pcm_a.sample_out[0]), 16384);
    check("d192_ch1", int'(pcm_a.sample_out[1]), 16384);

    // Enable dropped mid-window: partial window discarded, outputs held.
    start_a(MConst, 1'b0);
    goto_a(5000);
    en_a = 1'b0;
    nv = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (pcm_a.sample_valid_out) nv++;
    end
    check("drop_no_valid_idle", nv, 0);
    check("drop_hold_ch0", int'(pcm_a.sample_out[0]), 16384);
    check("drop_hold_ch1", int'(pcm_a.sample_out[1]), 16384);
    @(posedge clk_in); #1;
    en_a = 1'b1;
    t0 = cyc + 1;
    wait_valid(1'b0, 9000, at);
    check("reenable_first_valid_cycle", at - t0, 8192);
    check("reenable_ch0", int'(pcm_a.sample_out[0]), -32768);

    // Asynchronous reset mid-window while the mic clock is high.
    start_a(MConst, 1'b1);
    goto_a(3008);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mic_clk", int'(mic_clk_a), 0);
    check("async_rst_valid", int'(pcm_a.sample_valid_out), 0);
    check("async_rst_ch0", int'(pcm_a.sample_out[0]), 0);
    check("async_rst_ch1", int'(pcm_a.sample_out[1]), 0);
    @(posedge clk_in); #1;
    en_a = 1'b0;
    @(posedge clk_in); #1;
    rst_n = 1'b1;

    // 128 ones of 256 gives the midpoint.
    start_a(M128, 1'b0);
    wait_valid(1'b0, 9000, at);
    check("d128_ch0", int'(pcm_a.sample_out[0]), 0);
    check("d128_ch1", int'(pcm_a.sample_out[1]), 0);

    // Enable falls on the final tick: no valid, outputs unchanged.
    start_a(MConst, 1'b1);
    goto_a(8191);
    en_a = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (pcm_a.sample_valid_out) nv++;
    end
    check("final_tick_drop_valids", nv, 0);
    check("final_tick_drop_ch0", int'(pcm_a.sample_out[0]), 0);

    // Random bits: values come from the model comparison.
    start_a(MRand, 1'b0);
    wait_valid(1'b0, 9000, at);
    check("rand_first_valid_cycle", at - t0, 8192);
    @(posedge clk_in); #1;
    en_a = 1'b0;

    // Small mono configuration.
    @(posedge clk_in); #1;
    mode_b = 0;
    en_b = 1'b1;
    t0b = cyc + 1;
    @(posedge clk_in);
    first_tick = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      if (pcm_b.pdm_tick_out && first_tick < 0) first_tick = k;
    end
    check("b_first_tick_cycle", first_tick, 7);
    wait_valid(1'b1, 200, at);
    check("b_first_valid_cycle", at - t0b, 128);
    check("b_ones", int'(pcm_b.sample_out[0]), 127);
    @(posedge clk_in); #1;
    en_b = 1'b0;
    @(posedge clk_in); #1;
    mode_b = 1;
    en_b = 1'b1;
    t0b = cyc + 1;
    wait_valid(1'b1, 200, at);
    check("b_half_valid_cycle", at - t0b, 128);
    check("b_half", int'(pcm_b.sample_out[0]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
